// File: rtl/lsb_queue.sv
// In-order load/store buffer: captures operands at issue, wakes them from ROB commits,
// runs one memory access at a time from the head and keeps committed stores across a clear.
//   state  | meaning
//   S_IDLE | no access outstanding; head examined for issue
//   S_WAIT | access outstanding; head popped on mem_done
module lsb_queue #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             clear,
   input  logic             iss_valid,
   input  logic             iss_store,
   input  logic [2:0]       iss_funct3,
   input  logic             iss_rdy1,
   input  logic [TAG_W-1:0] iss_q1,
   input  logic [XLEN-1:0]  iss_v1,
   input  logic             iss_rdy2,
   input  logic [TAG_W-1:0] iss_q2,
   input  logic [XLEN-1:0]  iss_v2,
   input  logic [XLEN-1:0]  iss_imm,
   input  logic [TAG_W-1:0] iss_tag,
   output logic             full,
   input  logic             cmt_valid,
   input  logic [TAG_W-1:0] cmt_tag,
   input  logic [XLEN-1:0]  cmt_value,
   output logic             ld_valid,
   output logic [TAG_W-1:0] ld_tag,
   output logic [XLEN-1:0]  ld_value,
   output logic             mem_req,
   output logic             mem_we,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   output logic [2:0]       mem_len,
   input  logic             mem_done,
   input  logic [XLEN-1:0]  mem_rdata
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic             valid;
      logic             store;
      logic             committed;
      logic [2:0]       funct3;
      logic             rdy1;
      logic [TAG_W-1:0] q1;
      logic [XLEN-1:0]  v1;
      logic             rdy2;
      logic [TAG_W-1:0] q2;
      logic [XLEN-1:0]  v2;
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_t           state_q, state_d;
   logic             full_q, full_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic             ld_valid_q, ld_valid_d;
   logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, ld_value_q, ld_value_d;
   logic [TAG_W-1:0] ld_tag_q, ld_tag_d;
   logic [2:0]       mem_len_q, mem_len_d;

   logic             do_push, do_pop, cs, head_go;
   logic [PTR_W-1:0] n_skip, n_cmt, idx;
   logic [1:0]       scan_ph;
   logic [DEPTH-1:0] keep;

   function automatic logic [2:0] len_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   len_of = 3'd1;
         2'b01:   len_of = 3'd2;
         default: len_of = 3'd4;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
      case (f3)
         3'b000:  load_ext = {{(XLEN-8){d[7]}}, d[7:0]};
         3'b001:  load_ext = {{(XLEN-16){d[15]}}, d[15:0]};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, d[7:0]};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, d[15:0]};
         default: load_ext = d;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] store_mask(input logic [2:0] f3, input logic [XLEN-1:0] d);
      case (f3[1:0])
         2'b00:   store_mask = {{(XLEN-8){1'b0}}, d[7:0]};
         2'b01:   store_mask = {{(XLEN-16){1'b0}}, d[15:0]};
         default: store_mask = d;
      endcase
   endfunction

   always_comb begin
      ent_d       = ent_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      state_d     = state_q;
      full_d      = full_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_len_d   = mem_len_q;
      ld_valid_d  = 1'b0;
      ld_tag_d    = ld_tag_q;
      ld_value_d  = ld_value_q;
      do_push     = 1'b0;
      do_pop      = 1'b0;
      cs          = 1'b0;
      head_go     = 1'b0;
      n_skip      = '0;
      n_cmt       = '0;
      idx         = '0;
      scan_ph     = 2'd0;
      keep        = '0;
      if (rdy_in) begin
         if (cmt_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ent_q[i].valid) begin
                  if (!ent_q[i].rdy1 && ent_q[i].q1 == cmt_tag) begin
                     ent_d[i].rdy1 = 1'b1;
                     ent_d[i].v1   = cmt_value;
                  end
                  if (!ent_q[i].rdy2 && ent_q[i].q2 == cmt_tag) begin
                     ent_d[i].rdy2 = 1'b1;
                     ent_d[i].v2   = cmt_value;
                  end
                  if (ent_q[i].store && ent_q[i].tag == cmt_tag)
                     ent_d[i].committed = 1'b1;
               end
            end
         end
         case (state_q)
            S_IDLE: begin
               if (ent_q[head_q].store)
                  head_go = ent_q[head_q].rdy1 && ent_q[head_q].rdy2 && ent_q[head_q].committed;
               else
                  head_go = ent_q[head_q].rdy1 && !clear;
               if (count_q != '0 && ent_q[head_q].valid && head_go) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = ent_q[head_q].store;
                  mem_addr_d  = ent_q[head_q].v1 + ent_q[head_q].imm;
                  mem_len_d   = len_of(ent_q[head_q].funct3);
                  mem_wdata_d = ent_q[head_q].store ?
                                store_mask(ent_q[head_q].funct3, ent_q[head_q].v2) : '0;
                  state_d     = S_WAIT;
               end
            end
            S_WAIT: begin
               if (clear && !ent_q[head_q].store) begin
                  state_d = S_IDLE;
               end else if (mem_done) begin
                  do_pop  = 1'b1;
                  state_d = S_IDLE;
                  if (!ent_q[head_q].store) begin
                     ld_valid_d = 1'b1;
                     ld_tag_d   = ent_q[head_q].tag;
                     ld_value_d = load_ext(ent_q[head_q].funct3, mem_rdata);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (iss_valid && !full_q && !clear) begin
            do_push = 1'b1;
            ent_d[tail_q] = '{valid: 1'b1, store: iss_store, committed: 1'b0, funct3: iss_funct3,
               rdy1: iss_rdy1 || (cmt_valid && cmt_tag == iss_q1), q1: iss_q1,
               v1: iss_rdy1 ? iss_v1 : (cmt_valid && cmt_tag == iss_q1) ? cmt_value : iss_v1,
               rdy2: iss_rdy2 || (cmt_valid && cmt_tag == iss_q2), q2: iss_q2,
               v2: iss_rdy2 ? iss_v2 : (cmt_valid && cmt_tag == iss_q2) ? cmt_value : iss_v2,
               imm: iss_imm, tag: iss_tag};
         end
         if (clear) begin
            // An abandoned load at head is skipped so the surviving committed run becomes the new head.
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) < count_q) begin
                  idx = head_q + PTR_W'(i);
                  cs  = ent_q[idx].valid && ent_q[idx].store && ent_q[idx].committed;
                  if (scan_ph == 2'd0) begin
                     if (cs) begin
                        scan_ph   = 2'd1;
                        n_cmt     = n_cmt + PTR_W'(1);
                        keep[idx] = 1'b1;
                     end else begin
                        n_skip = n_skip + PTR_W'(1);
                     end
                  end else if (scan_ph == 2'd1) begin
                     if (cs) begin
                        n_cmt     = n_cmt + PTR_W'(1);
                        keep[idx] = 1'b1;
                     end else begin
                        scan_ph = 2'd2;
                     end
                  end
               end
            end
            for (int i = 0; i < DEPTH; i++)
               ent_d[i].valid = ent_d[i].valid & keep[i];
            head_d  = head_q + n_skip + PTR_W'(do_pop);
            tail_d  = head_q + n_skip + n_cmt;
            count_d = CNT_W'(n_cmt) - CNT_W'(do_pop);
         end else begin
            head_d  = head_q + PTR_W'(do_pop);
            tail_d  = tail_q + PTR_W'(do_push);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
         end
         if (do_pop)
            ent_d[head_q].valid = 1'b0;
         full_d = (count_d >= CNT_W'(DEPTH - 1));
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         full_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_len_q   <= '0;
         ld_valid_q  <= 1'b0;
         ld_tag_q    <= '0;
         ld_value_q  <= '0;
      end else begin
         ent_q       <= ent_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         state_q     <= state_d;
         full_q      <= full_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_len_q   <= mem_len_d;
         ld_valid_q  <= ld_valid_d;
         ld_tag_q    <= ld_tag_d;
         ld_value_q  <= ld_value_d;
      end
   end

   assign full      = full_q;
   assign mem_req   = mem_req_q & rdy_in;
   assign ld_valid  = ld_valid_q & rdy_in;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_len   = mem_len_q;
   assign ld_tag    = ld_tag_q;
   assign ld_value  = ld_value_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: table of load vectors plus hand-written store, full/wrap,
// clear, simultaneous push/pop, stall and asynchronous reset sequences.
module tb_lsb_queue;
   logic        clk_in, rst_in, rdy_in, clear;
   logic        iss_valid, iss_store, iss_rdy1, iss_rdy2;
   logic [2:0]  iss_funct3;
   logic [3:0]  iss_q1, iss_q2, iss_tag;
   logic [31:0] iss_v1, iss_v2, iss_imm;
   logic        full, cmt_valid;
   logic [3:0]  cmt_tag;
   logic [31:0] cmt_value;
   logic        ld_valid;
   logic [3:0]  ld_tag;
   logic [31:0] ld_value;
   logic        mem_req, mem_we, mem_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_len;

   int n_pass = 0;
   int n_total = 0;

   lsb_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .iss_valid(iss_valid), .iss_store(iss_store), .iss_funct3(iss_funct3),
      .iss_rdy1(iss_rdy1), .iss_q1(iss_q1), .iss_v1(iss_v1),
      .iss_rdy2(iss_rdy2), .iss_q2(iss_q2), .iss_v2(iss_v2),
      .iss_imm(iss_imm), .iss_tag(iss_tag), .full(full),
      .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .cmt_value(cmt_value),
      .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_value(ld_value),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] v1;
      logic [31:0] imm;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [2:0]  exp_len;
      logic [31:0] exp_val;
   } ld_vec_t;

   ld_vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      #2;
      rst_in = 1'b0;
   endtask

   task automatic push(input logic st, input logic [2:0] f3, input logic r1, input logic [3:0] q1,
                       input logic [31:0] v1, input logic r2, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [3:0] tag);
      iss_valid = 1'b1; iss_store = st; iss_funct3 = f3;
      iss_rdy1 = r1; iss_q1 = q1; iss_v1 = v1;
      iss_rdy2 = r2; iss_q2 = 4'd0; iss_v2 = v2;
      iss_imm = imm; iss_tag = tag;
      step();
      iss_valid = 1'b0;
   endtask

   task automatic commit(input logic [3:0] tag, input logic [31:0] val);
      cmt_valid = 1'b1; cmt_tag = tag; cmt_value = val;
      step();
      cmt_valid = 1'b0;
   endtask

   task automatic wait_req(input int maxc, output bit got);
      got = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (mem_req) begin
            got = 1'b1;
            break;
         end
         step();
      end
      if (!got && mem_req) got = 1'b1;
   endtask

   initial begin
      bit got, saw;
      int nreq, nwr, nld;
      logic [31:0] waddr [2];
      logic [31:0] wdat [2];

      vecs[0] = '{3'b010, 32'h100,      32'h4,        32'hDEADBEEF, 32'h104, 3'd4, 32'hDEADBEEF};
      vecs[1] = '{3'b000, 32'h1000,     32'hFFFFFFFF, 32'h12345680, 32'hFFF, 3'd1, 32'hFFFFFF80};
      vecs[2] = '{3'b100, 32'h20,       32'h0,        32'hFFFFFF80, 32'h20,  3'd1, 32'h00000080};
      vecs[3] = '{3'b001, 32'hFFFFFFFE, 32'h4,        32'h00008001, 32'h2,   3'd2, 32'hFFFF8001};
      vecs[4] = '{3'b101, 32'h300,      32'h10,       32'hAAAA8001, 32'h310, 3'd2, 32'h00008001};
      vecs[5] = '{3'b001, 32'h0,        32'h8,        32'hFFFF7FFF, 32'h8,   3'd2, 32'h00007FFF};
      vecs[6] = '{3'b111, 32'h44,       32'h0,        32'h80000001, 32'h44,  3'd4, 32'h80000001};
      vecs[7] = '{3'b000, 32'h50,       32'h0,        32'h0000017F, 32'h50,  3'd1, 32'h0000007F};

      rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
      iss_valid = 1'b0; iss_store = 1'b0; iss_funct3 = 3'd0; iss_rdy1 = 1'b0; iss_rdy2 = 1'b0;
      iss_q1 = 4'd0; iss_q2 = 4'd0; iss_v1 = '0; iss_v2 = '0; iss_imm = '0; iss_tag = 4'd0;
      cmt_valid = 1'b0; cmt_tag = 4'd0; cmt_value = '0; mem_done = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_full", full, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_len", mem_len, 0);
      check("rst_ld_valid", ld_valid, 0);
      check("rst_ld_tag", ld_tag, 0);
      check("rst_ld_value", ld_value, 0);
      check("rst_count", dut.count_q, 0);
      rst_in = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         push(1'b0, vecs[i].f3, 1'b1, 4'd0, vecs[i].v1, 1'b0, 32'h0, vecs[i].imm, 4'(i + 1));
         wait_req(6, got);
         check($sformatf("v%0d_req", i), got, 1);
         check($sformatf("v%0d_we", i), mem_we, 0);
         check($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
         check($sformatf("v%0d_len", i), mem_len, vecs[i].exp_len);
         mem_done = 1'b1; mem_rdata = vecs[i].rdata;
         step();
         mem_done = 1'b0;
         check($sformatf("v%0d_ld_valid", i), ld_valid, 1);
         check($sformatf("v%0d_ld_tag", i), ld_tag, 32'(i + 1));
         check($sformatf("v%0d_ld_value", i), ld_value, vecs[i].exp_val);
         step();
         check($sformatf("v%0d_ld_pulse_end", i), ld_valid, 0);
      end

      // store waits on base tag 3, then on its own commit
      do_reset();
      push(1'b1, 3'b010, 1'b0, 4'd3, 32'h0, 1'b1, 32'hCAFEF00D, 32'h8, 4'd5);
      commit(4'd3, 32'h200);
      saw = 1'b0;
      for (int i = 0; i < 4; i++) begin
         saw |= mem_req;
         step();
      end
      check("sw_no_req_before_commit", saw, 0);
      commit(4'd5, 32'h0);
      wait_req(6, got);
      check("sw_req", got, 1);
      check("sw_we", mem_we, 1);
      check("sw_addr", mem_addr, 32'h208);
      check("sw_wdata", mem_wdata, 32'hCAFEF00D);
      check("sw_len", mem_len, 4);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      check("sw_count_after", dut.count_q, 0);
      check("sw_no_ld_valid", ld_valid, 0);

      // same-cycle wakeup at push, byte store masking
      cmt_valid = 1'b1; cmt_tag = 4'd7; cmt_value = 32'h400;
      push(1'b1, 3'b000, 1'b0, 4'd7, 32'hBAD, 1'b1, 32'h12345678, 32'h1, 4'd6);
      cmt_valid = 1'b0;
      commit(4'd6, 32'h0);
      wait_req(6, got);
      check("sb_req", got, 1);
      check("sb_addr", mem_addr, 32'h401);
      check("sb_wdata", mem_wdata, 32'h78);
      check("sb_len", mem_len, 1);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;

      // fill to DEPTH-1, ignored push, tail wrap
      do_reset();
      for (int k = 0; k < 15; k++)
         push(1'b0, 3'b010, 1'b0, 4'd9, 32'h0, 1'b0, 32'h0, 32'h0, 4'(k));
      check("fill_full", full, 1);
      check("fill_count", dut.count_q, 15);
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd15);
      check("full_push_ignored_count", dut.count_q, 15);
      check("full_push_ignored_tail", dut.tail_q, 15);
      commit(4'd9, 32'h1000);
      wait_req(6, got);
      check("fill_req", got, 1);
      check("fill_addr", mem_addr, 32'h1000);
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      check("pop_count", dut.count_q, 14);
      check("pop_full_clear", full, 0);
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0, 4'd1);
      check("wrap_tail", dut.tail_q, 0);
      check("wrap_count", dut.count_q, 15);
      check("wrap_full", full, 1);

      // simultaneous push and pop
      do_reset();
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h10, 1'b0, 32'h0, 32'h0, 4'd2);
      wait_req(6, got);
      check("pp_req", got, 1);
      mem_done = 1'b1; mem_rdata = 32'h55;
      push(1'b0, 3'b010, 1'b0, 4'd4, 32'h0, 1'b0, 32'h0, 32'h0, 4'd3);
      mem_done = 1'b0;
      check("pp_count", dut.count_q, 1);
      check("pp_head", dut.head_q, 1);
      check("pp_tail", dut.tail_q, 2);
      check("pp_ld_valid", ld_valid, 1);
      check("pp_ld_value", ld_value, 32'h55);

      // clear with a load in WAIT and two committed stores behind it
      do_reset();
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h40, 1'b0, 32'h0, 32'h0, 4'd1);
      push(1'b1, 3'b010, 1'b1, 4'd0, 32'h80, 1'b1, 32'h11, 32'h0, 4'd2);
      push(1'b1, 3'b010, 1'b1, 4'd0, 32'h84, 1'b1, 32'h22, 32'h0, 4'd3);
      push(1'b0, 3'b010, 1'b0, 4'd8, 32'h0, 1'b0, 32'h0, 32'h0, 4'd4);
      push(1'b0, 3'b010, 1'b0, 4'd8, 32'h0, 1'b0, 32'h0, 32'h0, 4'd5);
      commit(4'd2, 32'h0);
      commit(4'd3, 32'h0);
      check("clr_pre_count", dut.count_q, 5);
      check("clr_pre_load_addr", mem_addr, 32'h40);
      clear = 1'b1; mem_done = 1'b1; mem_rdata = 32'h99;
      step();
      clear = 1'b0;
      check("clr_count", dut.count_q, 2);
      check("clr_no_ld_valid", ld_valid, 0);
      step();
      mem_done = 1'b0;
      nreq = 0; nwr = 0; nld = 0;
      waddr[0] = '0; waddr[1] = '0; wdat[0] = '0; wdat[1] = '0;
      for (int i = 0; i < 30; i++) begin
         if (ld_valid) nld++;
         if (mem_req) begin
            if (nreq < 2) begin
               waddr[nreq] = mem_addr;
               wdat[nreq] = mem_wdata;
            end
            nreq++;
            if (mem_we) nwr++;
            mem_done = 1'b1;
         end else begin
            mem_done = 1'b0;
         end
         step();
      end
      mem_done = 1'b0;
      check("clr_req_count", nreq, 2);
      check("clr_write_count", nwr, 2);
      check("clr_ld_valid_count", nld, 0);
      check("clr_w0_addr", waddr[0], 32'h80);
      check("clr_w0_data", wdat[0], 32'h11);
      check("clr_w1_addr", waddr[1], 32'h84);
      check("clr_w1_data", wdat[1], 32'h22);
      check("clr_final_count", dut.count_q, 0);

      // global stall
      do_reset();
      rdy_in = 1'b0;
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h10, 1'b0, 32'h0, 32'h0, 4'd1);
      step();
      check("stall_count", dut.count_q, 0);
      check("stall_req", mem_req, 0);
      rdy_in = 1'b1;

      // asynchronous reset in WAIT, between clock edges
      push(1'b0, 3'b010, 1'b1, 4'd0, 32'h300, 1'b0, 32'h0, 32'h0, 4'd7);
      push(1'b0, 3'b010, 1'b0, 4'd8, 32'h0, 1'b0, 32'h0, 32'h0, 4'd8);
      check("ar_pre_req", mem_req, 1);
      check("ar_pre_addr", mem_addr, 32'h300);
      rst_in = 1'b1;
      #1;
      check("ar_req", mem_req, 0);
      check("ar_addr", mem_addr, 0);
      check("ar_len", mem_len, 0);
      check("ar_count", dut.count_q, 0);
      check("ar_state_idle", dut.state_q, 0);
      #1;
      rst_in = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
